// File: rtl/hex_display_scheduler.sv
// rtl/hex_display_scheduler.sv - time-shares one seven-segment decoder across NUM_DIGITS held displays
module hex_display_scheduler #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_i,
    input  logic                    blank_lz,
    input  logic                    load_valid,
    output logic                    load_ready,
    output logic [3:0]              dec_a,
    input  logic [6:0]              dec_seg,
    output logic [7*NUM_DIGITS-1:0] hex_o,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic                    lz;
    logic [6:0]              seg_q [NUM_DIGITS];
    logic [3:0]              nib   [NUM_DIGITS];

    logic accept;
    logic capture;
    logic last_digit;
    logic upper_zero;
    logic blank;

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib[k] = shadow[4*k +: 4];
        end
    end

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if ((IDX_W'(k) >= idx) && (nib[k] != 4'h0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign blank      = lz && (idx != '0) && upper_zero;
    assign capture    = (state == SCAN) && (cnt == CNT_LAST);
    assign last_digit = (idx == IDX_LAST);
    assign accept     = load_valid && load_ready;

    always_comb begin
        state_n    = state;
        load_ready = 1'b0;
        busy       = 1'b0;
        dec_a      = 4'h0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_n = SCAN;
                end
            end
            SCAN: begin
                busy  = 1'b1;
                dec_a = nib[idx];
                if (capture && last_digit) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            shadow     <= '0;
            lz         <= 1'b0;
            frame_done <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                seg_q[k] <= 7'h7F;
            end
        end else begin
            state      <= state_n;
            frame_done <= capture && last_digit;
            if (accept) begin
                shadow <= value_i;
                lz     <= blank_lz;
                idx    <= '0;
                cnt    <= '0;
            end else if (state == SCAN) begin
                if (capture) begin
                    seg_q[idx] <= blank ? 7'h7F : dec_seg;
                    cnt        <= '0;
                    if (!last_digit) begin
                        idx <= idx + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Segment outputs are active-low; 7'h7F leaves a display dark.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_hex
        assign hex_o[7*g +: 7] = seg_q[g];
    end

endmodule

// File: doc/hex_display_scheduler.md
Name: hex_display_scheduler

Overview:
- Time-shares one combinational HEX_SevenSeg decoder (4-bit nibble in, 7-bit segment pattern out) across NUM_DIGITS seven-segment displays.
- Accepts a packed hex value through a valid/ready handshake and presents each nibble to the shared decoder in turn.
- Captures each decoded pattern into a per-digit holding register that drives the board's static HEX outputs.
- Sits between the ALU result path and the display pins.

Parameters:
- NUM_DIGITS, 4, number of displays served (range 1..8).
- SCAN_DIV, 4, cycles each nibble is held on dec_a before its pattern is captured (minimum 1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- value_i  input  4*NUM_DIGITS  packed nibbles; digit k is value_i[4k+3:4k], and digit 0 is least significant.
- blank_lz  input  1  leading-zero blanking enable; sampled together with value_i.
- load_valid  input  1  requester offers value_i and blank_lz.
- load_ready  output  1  high only in IDLE.
- dec_a  output  4  nibble driven to the shared decoder's a input.
- dec_seg  input  7  segment pattern returned by the decoder's seg0 output.
- hex_o  output  7*NUM_DIGITS  held segment pattern; digit k is hex_o[7k+6:7k].
- busy  output  1  high in SCAN.
- frame_done  output  1  one-cycle pulse after the last digit is captured.

Behaviour:
- Reset (rst=1 at an edge), whether idle or mid-scan:
  - state=IDLE, idx=0, cnt=0, shadow=0, blank flag=0.
  - dec_a=4'h0, load_ready=1 after the edge, busy=0, frame_done=0.
  - Every hex_o digit=7'h7F (all segments off, active-low).
  - A partial frame is discarded.
- FSM states: IDLE, SCAN.
- IDLE:
  - load_ready=1, dec_a=4'h0.
  - On load_valid&&load_ready at edge E0: latch shadow<=value_i and lz<=blank_lz; set idx=0, cnt=0; go to SCAN.
  - If load_valid=0, stay in IDLE; hex_o holds.
- SCAN:
  - load_ready=0; load_valid is ignored and the requester must hold its offer.
  - dec_a=shadow nibble[idx], combinationally from idx.
  - cnt increments every cycle.
  - On the edge where cnt==SCAN_DIV-1:
    - hex_o digit idx <= blank ? 7'h7F : dec_seg; cnt<=0.
    - If idx==NUM_DIGITS-1: go to IDLE and pulse frame_done. Otherwise idx<=idx+1.
- Blank rule: digit idx is blanked iff lz=1, idx!=0, and shadow nibbles idx..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- Timing:
  - Digit k is captured at edge E0+(k+1)*SCAN_DIV.
  - frame_done=1 for the single cycle following edge E0+NUM_DIGITS*SCAN_DIV.
  - load_ready=1 in that same cycle, so back-to-back loads are allowed; minimum frame period is NUM_DIGITS*SCAN_DIV+1 cycles.
- hex_o digits not yet captured in the current frame keep their previous-frame values. Only one digit changes per capture edge, so there is no global blank or flicker during an update.
- value_i and blank_lz changes after E0 have no effect until the next accepted load.
- idx width is clog2(NUM_DIGITS) (minimum 1); cnt width is clog2(SCAN_DIV) (minimum 1). Neither wraps past its terminal value.
- SCAN_DIV=1 is legal: one digit per cycle, and dec_a changes every cycle.

Test Plan (bench instantiates HEX_SevenSeg as the shared decoder; NUM_DIGITS=4, SCAN_DIV=2):
1. Reset held 3 cycles, then released:
   - All hex_o digits=7'h7F, load_ready=1, busy=0, dec_a=0.
   - With load_valid=0 for 20 cycles, all outputs hold those values.
2. Load 16'h3A0F with blank_lz=0 at E0:
   - dec_a sequence is F,F,0,0,A,A,3,3.
   - Digits 0..3 equal the decoder patterns for F,0,A,3, captured at E0+2, +4, +6, +8.
   - frame_done pulses exactly one cycle, at E0+8.
3. Load 16'h0005 with blank_lz=1:
   - Digit0 = pattern for 5; digits 1–3 = 7'h7F.
   - Reload 16'h0005 with blank_lz=0: digits 1–3 = pattern for 0.
4. Hold load_valid=1 with 16'h1111 during an active scan:
   - The offer is not accepted until load_ready rises in the frame_done cycle.
   - The second frame starts at that edge, giving a 9-cycle period.
   - The first frame's digits are overwritten one at a time in order.
5. Assert rst at E0+5, mid-frame:
   - Next cycle: all hex_o=7'h7F, state IDLE, load_ready=1.
   - No frame_done pulse occurs.
   - A new load of 16'hFFFF then completes normally with all digits showing F.
